// File: rtl/attn_sched_pkg.sv
// Shared types and constants for the attention-score engine scheduler.
// Holds the FSM state encoding, counter widths and a timer width helper.
package attn_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam int ERR_CNT_W = 8;

    // The timer must be able to hold TIMEOUT_CYCLES itself, not just TIMEOUT_CYCLES-1.
    function automatic int timer_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_gnt+1 (mod NUM_REQ)
// and reports the first requesting index plus an any-request flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Rotating priority search; the first hit after last_gnt wins.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s = IDX_W'((int'(last_gnt) + i) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                winner  = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/attn_score_sched.sv
// Round-robin scheduler sharing one attention-score engine among NUM_REQ
// requesters, with a per-job timeout watchdog and saturating error count.
module attn_score_sched
    import attn_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [IDX_W-1:0]     sel,
    output logic                 eng_start,
    input  logic                 eng_done,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic                 resp_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                   TIMER_W      = timer_w(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0]   TIMER_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX      = {ERR_CNT_W{1'b1}};
    localparam logic [IDX_W-1:0]     LAST_GNT_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0     = NUM_REQ'(1);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDX_W-1:0]       sel_r;
    logic [IDX_W-1:0]       last_gnt_r;
    logic [TIMER_W-1:0]     timer_r;
    logic [ERR_CNT_W-1:0]   err_cnt_r;
    logic [NUM_REQ-1:0]     req_ready_r;
    logic                   eng_start_r;
    logic [NUM_REQ-1:0]     resp_valid_r;
    logic                   resp_err_r;
    logic                   busy_r;
    logic [IDX_W-1:0]       winner_s;
    logic                   any_req_s;
    logic                   timeout_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .last_gnt  (last_gnt_r),
        .winner    (winner_s),
        .any_valid (any_req_s)
    );

    assign timeout_s = (timer_r == TIMER_LAST);

    // Next-state decode; done beats timeout when both land in the same RUN cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (eng_done || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RESP: begin
                if (resp_ready[sel_r]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, timer, error counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sel_r        <= '0;
            last_gnt_r   <= LAST_GNT_RST;
            timer_r      <= '0;
            err_cnt_r    <= '0;
            req_ready_r  <= '0;
            eng_start_r  <= 1'b0;
            resp_valid_r <= '0;
            resp_err_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            req_ready_r <= '0;
            eng_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        sel_r       <= winner_s;
                        req_ready_r <= ONE_HOT0 << winner_s;
                        eng_start_r <= 1'b1;
                    end
                end
                ST_START: timer_r <= '0;
                ST_RUN: begin
                    if (eng_done) begin
                        resp_valid_r <= ONE_HOT0 << sel_r;
                        resp_err_r   <= 1'b0;
                    end else if (timeout_s) begin
                        resp_valid_r <= ONE_HOT0 << sel_r;
                        resp_err_r   <= 1'b1;
                        if (err_cnt_r != ERR_MAX) begin
                            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready[sel_r]) begin
                        resp_valid_r <= '0;
                        resp_err_r   <= 1'b0;
                        last_gnt_r   <= sel_r;
                    end
                end
                default: begin
                    resp_valid_r <= '0;
                    resp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign sel        = sel_r;
    assign eng_start  = eng_start_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign busy       = busy_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_attn_score_sched.sv
// Directed self-checking bench for attn_score_sched (NUM_REQ=4, short timeout).
module tb_attn_score_sched;

    localparam int NREQ = 4;
    localparam int TO   = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [1:0] sel;
    logic       eng_start;
    logic       eng_done;
    logic [3:0] resp_valid;
    logic [3:0] resp_ready;
    logic       resp_err;
    logic       busy;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int err_exp  = 0;

    always #5 clk = ~clk;

    attn_score_sched #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .sel        (sel),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_err   (resp_err),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 4'b0000;
        eng_done   = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        err_exp = 0;
    endtask

    // Raise a request and return in the START cycle (eng_start high).
    task automatic issue(input logic [3:0] mask, output int ok);
        ok = 0;
        req_valid = mask;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            tick();
            if (eng_start === 1'b1) ok = 1;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 4'b0000;
        eng_done   = 1'b0;
        tick();
        checks++;
        if ({sel, req_ready, eng_start, resp_valid, resp_err, busy, err_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {sel, req_ready, eng_start, resp_valid, resp_err, busy, err_cnt});
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || eng_start !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b eng_start=%b exp 0/0", busy, eng_start);
        end
    endtask

    task automatic test_fairness();
        int n;
        int done_at;
        int starts[5];
        int sels[5];
        do_reset();
        n = 0;
        done_at = -1;
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        for (int cyc = 1; cyc <= 120 && !(n == 5 && busy === 1'b0); cyc++) begin
            tick();
            eng_done = (cyc == done_at);
            if (eng_start === 1'b1 && n < 5) begin
                starts[n] = cyc;
                sels[n]   = int'(sel);
                checks++;
                if (req_ready !== (4'b0001 << (n % 4))) begin
                    failures++;
                    $display("FAIL fair_req_ready job=%0d got=%b exp=%b", n, req_ready, 4'b0001 << (n % 4));
                end
                done_at = cyc + 6;
                n++;
                if (n == 5) req_valid = 4'b0000;
            end
        end
        eng_done   = 1'b0;
        resp_ready = 4'b0000;
        checks++;
        if (n != 5 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fair_jobs got=%0d busy=%b exp=5 busy=0", n, busy);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (sels[k] != k % 4) begin
                failures++;
                $display("FAIL fair_order job=%0d got=%0d exp=%0d", k, sels[k], k % 4);
            end
            if (k > 0) begin
                checks++;
                if (starts[k] - starts[k-1] != 9) begin
                    failures++;
                    $display("FAIL fair_spacing job=%0d got=%0d exp=9", k, starts[k] - starts[k-1]);
                end
            end
        end
    endtask

    task automatic test_single();
        resp_ready = 4'b0000;
        req_valid  = 4'b0100;
        tick();
        checks++;
        if (sel !== 2'd2 || req_ready !== 4'b0100 || eng_start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant sel=%0d req_ready=%b eng_start=%b busy=%b exp 2/0100/1/1",
                     sel, req_ready, eng_start, busy);
        end
        req_valid = 4'b0000;
        tick();
        checks++;
        if (eng_start !== 1'b0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL single_pulse eng_start=%b req_ready=%b exp 0/0000", eng_start, req_ready);
        end
        for (int i = 0; i < 18; i++) tick();
        checks++;
        if (resp_valid !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_wait resp_valid=%b busy=%b exp 0000/1", resp_valid, busy);
        end
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checks++;
        if (resp_valid !== 4'b0100 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_resp resp_valid=%b resp_err=%b exp 0100/0", resp_valid, resp_err);
        end
        tick();
        resp_ready = 4'b0100;
        tick();
        resp_ready = 4'b0000;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL single_done busy=%b resp_valid=%b exp 0/0000", busy, resp_valid);
        end
    endtask

    task automatic test_timeout();
        int ok;
        issue(4'b0001, ok);
        checks++;
        if (ok == 0) begin
            failures++;
            $display("FAIL timeout_start got=no_start exp=start");
        end
        for (int i = 0; i < TO; i++) tick();
        checks++;
        if (resp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL timeout_early resp_valid=%b exp=0000", resp_valid);
        end
        tick();
        err_exp++;
        checks++;
        if (resp_valid !== 4'b0001 || resp_err !== 1'b1 || err_cnt !== 8'(err_exp)) begin
            failures++;
            $display("FAIL timeout_resp resp_valid=%b resp_err=%b err_cnt=%0d exp 0001/1/%0d",
                     resp_valid, resp_err, err_cnt, err_exp);
        end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        checks++;
        if (resp_valid !== 4'b0001 || resp_err !== 1'b1 || err_cnt !== 8'(err_exp)) begin
            failures++;
            $display("FAIL timeout_late_done resp_valid=%b resp_err=%b err_cnt=%0d exp 0001/1/%0d",
                     resp_valid, resp_err, err_cnt, err_exp);
        end
        resp_ready = 4'b0001;
        tick();
        resp_ready = 4'b0000;
        eng_done   = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || eng_start !== 1'b0 || err_cnt !== 8'(err_exp)) begin
            failures++;
            $display("FAIL idle_stray_done busy=%b eng_start=%b err_cnt=%0d exp 0/0/%0d",
                     busy, eng_start, err_cnt, err_exp);
        end
    endtask

    task automatic test_race();
        int ok;
        issue(4'b0010, ok);
        checks++;
        if (ok == 0 || sel !== 2'd1) begin
            failures++;
            $display("FAIL race_start ok=%0d sel=%0d exp 1/1", ok, sel);
        end
        for (int i = 0; i < TO; i++) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checks++;
        if (resp_valid !== 4'b0010 || resp_err !== 1'b0 || err_cnt !== 8'(err_exp)) begin
            failures++;
            $display("FAIL race_done_wins resp_valid=%b resp_err=%b err_cnt=%0d exp 0010/0/%0d",
                     resp_valid, resp_err, err_cnt, err_exp);
        end
        resp_ready = 4'b0010;
        tick();
        resp_ready = 4'b0000;
    endtask

    task automatic test_backpressure();
        int ok;
        issue(4'b1000, ok);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        checks++;
        if (ok == 0 || resp_valid !== 4'b1000 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_resp ok=%0d resp_valid=%b resp_err=%b exp 1/1000/0", ok, resp_valid, resp_err);
        end
        for (int i = 0; i < 10; i++) begin
            eng_done   = (i % 2 == 0);
            resp_ready = (i % 2 == 1) ? 4'b0111 : 4'b0000;
            req_valid  = 4'b0110;
            tick();
            checks++;
            if (resp_valid !== 4'b1000 || sel !== 2'd3 || eng_start !== 1'b0 ||
                req_ready !== 4'b0000 || resp_err !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d resp_valid=%b sel=%0d eng_start=%b req_ready=%b exp 1000/3/0/0000",
                         i, resp_valid, sel, eng_start, req_ready);
            end
        end
        eng_done   = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 4'b1000;
        tick();
        resp_ready = 4'b0000;
        checks++;
        if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release resp_valid=%b busy=%b exp 0000/0", resp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int ok;
        issue(4'b0001, ok);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done   = 1'b0;
        resp_ready = 4'b0001;
        tick();
        resp_ready = 4'b0000;
        issue(4'b0010, ok);
        tick();
        tick();
        tick();
        checks++;
        if (ok == 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_running ok=%0d busy=%b exp 1/1", ok, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, req_ready, eng_start, resp_valid, resp_err, busy, err_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL mid_reset_async got=%h exp=0",
                     {sel, req_ready, eng_start, resp_valid, resp_err, busy, err_cnt});
        end
        tick();
        rst_n   = 1'b1;
        err_exp = 0;
        req_valid = 4'b1001;
        tick();
        req_valid = 4'b0000;
        checks++;
        if (eng_start !== 1'b1 || sel !== 2'd0 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_first_grant eng_start=%b sel=%0d req_ready=%b exp 1/0/0001",
                     eng_start, sel, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_timeout();
        test_race();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
